// File: rtl/id_stage_param.sv
// MIPS decode stage: register file with same-cycle WB bypass, main control
// decode, immediate sign-extension, load-use hazard detection and the
// ID/EX pipeline register with bubble insertion on stall or branch flush.
module id_stage_param #(
  parameter int DATA_W    = 32,
  parameter int NREGS     = 32,
  parameter bit REG0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [31:0]       IF_ID_Instr,
  input  logic [DATA_W-1:0] IF_ID_NPC,
  input  logic [4:0]        MEM_WB_Writereg,
  input  logic [DATA_W-1:0] MEM_WB_Writedata,
  input  logic              ID_EX_MemRead,
  input  logic [4:0]        ID_EX_Rt,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        WB,
  output logic [2:0]        M,
  output logic [3:0]        EX,
  output logic [DATA_W-1:0] NPC,
  output logic [DATA_W-1:0] rdata1out,
  output logic [DATA_W-1:0] rdata2out,
  output logic [DATA_W-1:0] IR,
  output logic [4:0]        instrout_2016,
  output logic [4:0]        instrout_1511
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [DATA_W-1:0] rf_q [NREGS];

  logic [4:0]        rs, rt;
  logic              wr_en, hazard;
  logic [DATA_W-1:0] rdata1_d, rdata2_d, imm_d;
  logic [8:0]        ctrl_d;

  logic [1:0]        wb_q;
  logic [2:0]        m_q;
  logic [3:0]        ex_q;
  logic [DATA_W-1:0] npc_q, rd1_q, rd2_q, ir_q;
  logic [4:0]        f2016_q, f1511_q;

  assign rs = IF_ID_Instr[25:21];
  assign rt = IF_ID_Instr[20:16];

  // A write is legal only to an implemented register, and never to a hardwired r0.
  assign wr_en = RegWrite && (int'(MEM_WB_Writereg) < NREGS) &&
                 !(REG0_ZERO && (MEM_WB_Writereg == 5'd0));

  // rs read port: unimplemented/zero register reads 0, pending WB write is forwarded.
  always_comb begin
    rdata1_d = '0;
    if ((int'(rs) < NREGS) && !(REG0_ZERO && (rs == 5'd0))) begin
      if (wr_en && (MEM_WB_Writereg == rs)) rdata1_d = MEM_WB_Writedata;
      else                                  rdata1_d = rf_q[rs[AW-1:0]];
    end
  end

  // rt read port: same rules as rs.
  always_comb begin
    rdata2_d = '0;
    if ((int'(rt) < NREGS) && !(REG0_ZERO && (rt == 5'd0))) begin
      if (wr_en && (MEM_WB_Writereg == rt)) rdata2_d = MEM_WB_Writedata;
      else                                  rdata2_d = rf_q[rt[AW-1:0]];
    end
  end

  // Main control decode: {WB[1:0], M[2:0], EX[3:0]} from the opcode.
  always_comb begin
    case (IF_ID_Instr[31:26])
      6'b000000: ctrl_d = 9'b10_000_1100;  // R-type
      6'b100011: ctrl_d = 9'b11_010_0001;  // lw
      6'b101011: ctrl_d = 9'b00_001_0001;  // sw
      6'b000100: ctrl_d = 9'b00_100_0010;  // beq
      default:   ctrl_d = 9'b00_000_0000;  // unsupported -> nop
    endcase
  end

  assign imm_d = {{(DATA_W-16){IF_ID_Instr[15]}}, IF_ID_Instr[15:0]};

  // Load-use: the load in EX targets a register this instruction reads.
  // A flush already kills the instruction, so it never needs to wait.
  assign hazard = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                  ((ID_EX_Rt == rs) || (ID_EX_Rt == rt));
  assign stall  = hazard && !flush && !rst;

  // Register file write and ID/EX latch; stall or flush turns the control into a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      wb_q    <= '0;
      m_q     <= '0;
      ex_q    <= '0;
      npc_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      ir_q    <= '0;
      f2016_q <= '0;
      f1511_q <= '0;
    end else begin
      if (wr_en) rf_q[MEM_WB_Writereg[AW-1:0]] <= MEM_WB_Writedata;
      if (stall || flush) begin
        wb_q <= '0;
        m_q  <= '0;
        ex_q <= '0;
      end else begin
        wb_q <= ctrl_d[8:7];
        m_q  <= ctrl_d[6:4];
        ex_q <= ctrl_d[3:0];
      end
      npc_q   <= IF_ID_NPC;
      rd1_q   <= rdata1_d;
      rd2_q   <= rdata2_d;
      ir_q    <= imm_d;
      f2016_q <= IF_ID_Instr[20:16];
      f1511_q <= IF_ID_Instr[15:11];
    end
  end

  assign WB            = wb_q;
  assign M             = m_q;
  assign EX            = ex_q;
  assign NPC           = npc_q;
  assign rdata1out     = rd1_q;
  assign rdata2out     = rd2_q;
  assign IR            = ir_q;
  assign instrout_2016 = f2016_q;
  assign instrout_1511 = f1511_q;

endmodule

// File: tb/tb_id_stage_param.sv
// Directed test-plan steps followed by randomized traffic, all checked
// against a table-driven model of the decode stage (default parameters).
module tb_id_stage_param;

  logic        clk = 1'b0;
  logic        rst, RegWrite, ID_EX_MemRead, flush, stall;
  logic [31:0] IF_ID_Instr, IF_ID_NPC, MEM_WB_Writedata;
  logic [4:0]  MEM_WB_Writereg, ID_EX_Rt, instrout_2016, instrout_1511;
  logic [1:0]  WB;
  logic [2:0]  M;
  logic [3:0]  EX;
  logic [31:0] NPC, rdata1out, rdata2out, IR;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_rf [32];

  always #5 clk = ~clk;

  id_stage_param dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .IF_ID_Instr(IF_ID_Instr),
    .IF_ID_NPC(IF_ID_NPC), .MEM_WB_Writereg(MEM_WB_Writereg),
    .MEM_WB_Writedata(MEM_WB_Writedata), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_Rt(ID_EX_Rt), .flush(flush), .stall(stall), .WB(WB), .M(M), .EX(EX),
    .NPC(NPC), .rdata1out(rdata1out), .rdata2out(rdata2out), .IR(IR),
    .instrout_2016(instrout_2016), .instrout_1511(instrout_1511)
  );

  // {WB, M, EX} per opcode, straight from the decode table.
  function automatic logic [8:0] ctrl_of(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b10_000_1100;
      6'h23:   return 9'b11_010_0001;
      6'h2b:   return 9'b00_001_0001;
      6'h04:   return 9'b00_100_0010;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] idx, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 5'd0)           return 32'd0;
    if (we && wa == idx)       return wd;
    return m_rf[idx];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive at negedge, check comb stall, then registered outputs.
  task automatic step(input logic r, input logic [31:0] ins, input logic [31:0] npc,
                      input logic rw, input logic [4:0] wa, input logic [31:0] wd,
                      input logic mr, input logic [4:0] xrt, input logic fl);
    logic [4:0]  rs, rt;
    logic        haz, e_stall;
    logic [8:0]  e_ctrl;
    logic [31:0] e_r1, e_r2, e_ir, e_npc;
    logic [9:0]  e_fld;
    @(negedge clk);
    rst = r; IF_ID_Instr = ins; IF_ID_NPC = npc; RegWrite = rw;
    MEM_WB_Writereg = wa; MEM_WB_Writedata = wd; ID_EX_MemRead = mr;
    ID_EX_Rt = xrt; flush = fl;
    #1;
    rs = ins[25:21];
    rt = ins[20:16];
    haz     = mr && (xrt != 0) && (xrt == rs || xrt == rt);
    e_stall = haz && !fl && !r;
    check("stall", {63'd0, stall}, {63'd0, e_stall});
    if (r) begin
      e_ctrl = '0; e_r1 = '0; e_r2 = '0; e_ir = '0; e_npc = '0; e_fld = '0;
    end else begin
      e_ctrl = (e_stall || fl) ? 9'd0 : ctrl_of(ins[31:26]);
      e_r1   = mread(rs, rw, wa, wd);
      e_r2   = mread(rt, rw, wa, wd);
      e_ir   = 32'($signed(ins[15:0]));
      e_npc  = npc;
      e_fld  = {ins[20:16], ins[15:11]};
    end
    @(posedge clk);
    #1;
    check("ctrl",  {55'd0, WB, M, EX}, {55'd0, e_ctrl});
    check("rdata1", {32'd0, rdata1out}, {32'd0, e_r1});
    check("rdata2", {32'd0, rdata2out}, {32'd0, e_r2});
    check("imm",   {32'd0, IR}, {32'd0, e_ir});
    check("npc",   {32'd0, NPC}, {32'd0, e_npc});
    check("fields", {54'd0, instrout_2016, instrout_1511}, {54'd0, e_fld});
    if (r) for (int i = 0; i < 32; i++) m_rf[i] = '0;
    else if (rw && wa != 0) m_rf[wa] = wd;
  endtask

  initial begin
    logic [31:0] ins;
    logic [5:0]  op;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    rst = 1'b1; RegWrite = 0; IF_ID_Instr = '0; IF_ID_NPC = '0;
    MEM_WB_Writereg = '0; MEM_WB_Writedata = '0; ID_EX_MemRead = 0;
    ID_EX_Rt = '0; flush = 0;

    // reset state
    step(1, 32'h00221000, 32'h4, 1, 5'd1, 32'h1234, 0, 5'd0, 0);
    check("reset_wb", {62'd0, WB}, 64'd0);
    // write r1, r2 under an unsupported opcode
    step(0, 32'hFC000000, 32'h8, 1, 5'd1, 32'h002300AA, 0, 5'd0, 0);
    step(0, 32'hFC000000, 32'hC, 1, 5'd2, 32'h10654321, 0, 5'd0, 0);
    // R-type read of r1, r2
    step(0, 32'h00221000, 32'h10, 0, 5'd0, 32'h0, 0, 5'd0, 0);
    check("rtype_r1",  {32'd0, rdata1out}, {32'd0, 32'h002300AA});
    check("rtype_r2",  {32'd0, rdata2out}, {32'd0, 32'h10654321});
    check("rtype_ctl", {55'd0, WB, M, EX}, {55'd0, 9'b10_000_1100});
    check("rtype_rd",  {59'd0, instrout_1511}, 64'd2);
    // same-cycle bypass
    step(0, 32'h00600000, 32'h14, 1, 5'd3, 32'h8C123456, 0, 5'd0, 0);
    check("bypass", {32'd0, rdata1out}, {32'd0, 32'h8C123456});
    // r0 write ignored, also while bypass would match
    step(0, 32'h00000000, 32'h18, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 0);
    step(0, 32'h00000000, 32'h1C, 0, 5'd0, 32'h0, 0, 5'd0, 0);
    check("reg0", {32'd0, rdata1out}, 64'd0);
    // lw decode with negative offset
    step(0, 32'h8C62FFFC, 32'h20, 0, 5'd0, 32'h0, 0, 5'd0, 0);
    check("lw_ctl", {55'd0, WB, M, EX}, {55'd0, 9'b11_010_0001});
    check("lw_imm", {32'd0, IR}, {32'd0, 32'hFFFFFFFC});
    // load-use stall, then flush overriding it
    step(0, 32'h00400000, 32'h24, 0, 5'd0, 32'h0, 1, 5'd2, 0);
    check("lu_bubble", {55'd0, WB, M, EX}, 64'd0);
    step(0, 32'h00400000, 32'h24, 0, 5'd0, 32'h0, 1, 5'd2, 1);
    // hazard on rt with ID_EX_Rt=0 must not stall
    step(0, 32'h00000000, 32'h28, 0, 5'd0, 32'h0, 1, 5'd0, 0);
    // reset mid-run, then read r1
    step(1, 32'h00221000, 32'h2C, 1, 5'd4, 32'hABCD, 1, 5'd1, 0);
    step(0, 32'h00200000, 32'h30, 0, 5'd0, 32'h0, 0, 5'd0, 0);
    check("rst_r1", {32'd0, rdata1out}, 64'd0);

    // randomized traffic over a small register window to force collisions
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2b;
        3: op = 6'h04;
        default: op = 6'($urandom);
      endcase
      ins = $urandom;
      ins[31:26] = op;
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      step(($urandom_range(0, 39) == 0), ins, $urandom, 1'($urandom),
           5'($urandom_range(0, 7)), $urandom, 1'($urandom),
           5'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage_param.md
Name: id_stage_param

Overview:
- Parametrised successor to the MIPS ID (decode) stage. Contains the register file, main control decode, immediate sign-extension and the ID/EX pipeline register.
- Adds features the previous decode stage lacks:
  - configurable data width and register count;
  - synchronous reset;
  - same-cycle WB-to-ID write bypass;
  - load-use hazard detection with bubble insertion;
  - branch flush.
- Sits between the IF/ID latch and the EX stage.

Parameters:
- DATA_W, 32: width of register data, NPC and sign-extended immediate.
- NREGS, 32: number of implemented registers (2..32). Register addresses stay 5 bits.
- REG0_ZERO, 1: when 1, register 0 reads as 0 and ignores writes.

Ports:
- clk  in  1  stage clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- RegWrite  in  1  WB-stage write enable.
- IF_ID_Instr  in  32  instruction from the IF/ID latch.
- IF_ID_NPC  in  DATA_W  next PC from the IF/ID latch.
- MEM_WB_Writereg  in  5  WB destination register.
- MEM_WB_Writedata  in  DATA_W  WB write data.
- ID_EX_MemRead  in  1  MemRead bit of the instruction currently in EX (fed back from M[1]).
- ID_EX_Rt  in  5  rt of the instruction currently in EX (fed back from instrout_2016).
- flush  in  1  branch-taken squash of the instruction in ID.
- stall  out  1  hazard stall to PC/IF-ID (combinational).
- WB  out  2  {RegWrite, MemtoReg}.
- M  out  3  {Branch, MemRead, MemWrite}.
- EX  out  4  {RegDst, ALUOp[1:0], ALUSrc}.
- NPC  out  DATA_W  registered next PC.
- rdata1out  out  DATA_W  registered rs data.
- rdata2out  out  DATA_W  registered rt data.
- IR  out  DATA_W  registered sign-extended Instr[15:0].
- instrout_2016  out  5  registered Instr[20:16].
- instrout_1511  out  5  registered Instr[15:11].

Behaviour:
- Reset (rst=1 at a clock edge):
  - All outputs registered to 0.
  - All NREGS registers cleared to 0.
  - Writes and decode are ignored that cycle.
  - rst has priority over RegWrite, flush and stall.
  - Reset mid-operation discards the in-flight instruction; the next edge with rst=0 resumes normally.
- Register file write:
  - Occurs at the rising edge when RegWrite=1 and MEM_WB_Writereg < NREGS.
  - Not performed when the index is 0 and REG0_ZERO=1.
- Reads are combinational on rs=Instr[25:21] and rt=Instr[20:16]:
  - Index >= NREGS reads 0.
  - Index 0 reads 0 when REG0_ZERO=1.
- Bypass: if RegWrite=1, MEM_WB_Writereg equals the read index, and the write is legal (rules above), the read returns MEM_WB_Writedata in the same cycle.
- Control decode on opcode Instr[31:26]:
  - 000000 (R): WB=10, M=000, EX=1100.
  - 100011 (lw): WB=11, M=010, EX=0001.
  - 101011 (sw): WB=00, M=001, EX=0001.
  - 000100 (beq): WB=00, M=100, EX=0010.
  - Any other opcode: all control bits 0 (nop).
- Sign extension: IR = {(DATA_W-16){Instr[15]}, Instr[15:0]}.
- Hazard detection:
  - hazard = ID_EX_MemRead && ID_EX_Rt != 0 && (ID_EX_Rt == rs || ID_EX_Rt == rt).
  - stall = hazard && !flush && !rst.
- ID/EX register (1-cycle latency from IF_ID_Instr to outputs):
  - Normal: latch all decoded fields.
  - stall=1 or flush=1: WB, M, EX load 0 (bubble). Data and field outputs still load current values (don't-care).
  - flush and hazard together: bubble, stall=0.

Test Plan:
- Write/read: rst 1 cycle, then write r1=002300AA and r2=10654321 (RegWrite=1, one per cycle). Then Instr=00221000 (R-type, rs=1, rt=2) → next edge rdata1out=002300AA, rdata2out=10654321, WB=10, M=000, EX=1100, instrout_1511=2.
- Bypass: RegWrite=1, Writereg=3, Writedata=8C123456, Instr with rs=3 in the same cycle → next edge rdata1out=8C123456.
- Reg0: write r0=FFFFFFFF with REG0_ZERO=1, then read rs=0 → rdata1out=0.
- lw decode: Instr=8C62FFFC → WB=11, M=010, EX=0001, IR=FFFFFFFC, instrout_2016=2.
- Load-use: ID_EX_MemRead=1, ID_EX_Rt=2, Instr rs=2 → stall=1 combinationally; next edge WB/M/EX=0. Adding flush=1 the same cycle → stall=0, bubble still issued.
- Reset mid-run: after writes, assert rst one edge → all outputs 0, and reading r1 returns 0.
